// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: FSM states and grant identities.
package rf_wb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_wb_state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } rf_wb_grant_e;

  // One-hot grant bit positions used by rr_arb2.
  localparam int unsigned GRANT_A_BIT = 0;
  localparam int unsigned GRANT_B_BIT = 1;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational; the last-grant history lives in the caller.
module rr_arb2
  import rf_wb_pkg::*;
(
  input  logic         v_a,
  input  logic         v_b,
  input  rf_wb_grant_e last_grant,
  output logic [1:0]   grant,
  output logic         grant_v
);

  always_comb begin
    grant = 2'b00;
    if (v_a && v_b) begin
      // Under contention the side that did not win last time goes first.
      if (last_grant == GNT_A) begin
        grant[GRANT_B_BIT] = 1'b1;
      end else begin
        grant[GRANT_A_BIT] = 1'b1;
      end
    end else begin
      grant[GRANT_A_BIT] = v_a;
      grant[GRANT_B_BIT] = v_b;
    end
  end

  assign grant_v = v_a | v_b;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: zero-fills every entry after reset/clear, then
// shares the port round-robin between ALU (A) and load/network (B) writeback.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int addr_width_p = 6,
  parameter int data_width_p = 32
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    clear_i,
  input  logic                    a_v_i,
  input  logic [addr_width_p-1:0] a_addr_i,
  input  logic [data_width_p-1:0] a_data_i,
  output logic                    a_ready_o,
  input  logic                    b_v_i,
  input  logic [addr_width_p-1:0] b_addr_i,
  input  logic [data_width_p-1:0] b_data_i,
  output logic                    b_ready_o,
  output logic                    rf_wen_o,
  output logic [addr_width_p-1:0] rf_addr_o,
  output logic [data_width_p-1:0] rf_data_o,
  output logic                    init_done_o,
  output rf_wb_state_e            dbg_state_o
);

  // Handshake: a write transfers in any cycle where v_i && ready_o; ready_o depends only on
  // state, clear_i, both valids and last_grant, and a waiting requester holds v/addr/data.

  localparam logic [addr_width_p-1:0] LAST_ADDR = '1;

  rf_wb_state_e            state;
  rf_wb_grant_e            last_grant;
  logic [addr_width_p-1:0] init_cnt;
  logic [1:0]              grant;
  logic                    grant_v;
  logic                    run_grant;

  rr_arb2 u_arb (
    .v_a        (a_v_i),
    .v_b        (b_v_i),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_v    (grant_v)
  );

  assign run_grant = reset_n_i && (state == RUN) && !clear_i && grant_v;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state      <= INIT;
      init_cnt   <= '0;
      last_grant <= GNT_B;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (clear_i) begin
            state    <= INIT;
            init_cnt <= '0;
          end else if (grant_v) begin
            last_grant <= grant[GRANT_A_BIT] ? GNT_A : GNT_B;
          end
        end
        default: begin
          state    <= INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    a_ready_o   = 1'b0;
    b_ready_o   = 1'b0;
    rf_wen_o    = 1'b0;
    rf_addr_o   = '0;
    rf_data_o   = '0;
    init_done_o = 1'b0;
    if (reset_n_i) begin
      if (state == INIT) begin
        rf_wen_o  = 1'b1;
        rf_addr_o = init_cnt;
      end else begin
        init_done_o = 1'b1;
        if (run_grant) begin
          rf_wen_o = 1'b1;
          if (grant[GRANT_A_BIT]) begin
            a_ready_o = 1'b1;
            rf_addr_o = a_addr_i;
            rf_data_o = a_data_i;
          end else begin
            b_ready_o = 1'b1;
            rf_addr_o = b_addr_i;
            rf_data_o = b_data_i;
          end
        end
      end
    end
  end

  assign dbg_state_o = state;

endmodule
